// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - multi-cycle execute controller driving an external ALU
module alu_ctrl_seq #(
  parameter int         DATA_WIDTH = 16,
  parameter logic [4:0] CMP_OP     = 5'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_neg,
  input  logic                  alu_grt,
  input  logic                  alu_eq,
  output logic                  done,
  output logic                  err,
  output logic                  br_valid,
  output logic                  br_taken,
  output logic [DATA_WIDTH-1:0] br_offset,
  input  logic [2:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t                state;
  logic [15:0]           ir;
  logic [DATA_WIDTH-1:0] rf [8];
  logic [DATA_WIDTH-1:0] res_q;
  logic                  eq_q;
  logic                  grt_q;

  // Zero and negative flags are not needed by any supported instruction.
  logic unused_flags;
  assign unused_flags = alu_zero ^ alu_neg;

  // Instruction field decode from the held instruction register.
  logic [4:0]            opcode;
  logic                  is_alu;
  logic                  is_li;
  logic                  is_br;
  logic [2:0]            rd;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] off_ext;

  assign opcode  = ir[15:11];
  assign is_alu  = (opcode <= 5'd14);
  assign is_li   = (opcode == 5'd15);
  assign is_br   = (opcode >= 5'd16) && (opcode <= 5'd18);
  assign rd      = ir[10:8];
  assign imm_ext = {{(DATA_WIDTH-8){ir[7]}}, ir[7:0]};
  assign off_ext = {{(DATA_WIDTH-5){ir[4]}}, ir[4:0]};

  // Fetch may only hand over a new instruction while the controller is idle.
  assign instr_ready = (state == IDLE);

  // rf[0] is never written, so it always reads back as zero.
  assign dbg_data = rf[dbg_addr];

  // Sequencer: IDLE -> DECODE -> EXEC -> WB, with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ir        <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_q     <= '0;
      eq_q      <= 1'b0;
      grt_q     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      br_valid  <= 1'b0;
      br_taken  <= 1'b0;
      br_offset <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      br_valid <= 1'b0;
      br_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          // LI and illegal opcodes leave the ALU operands untouched.
          if (is_alu) begin
            alu_a  <= rf[ir[7:5]];
            alu_b  <= rf[ir[4:2]];
            alu_op <= opcode;
          end else if (is_br) begin
            alu_a  <= rf[ir[10:8]];
            alu_b  <= rf[ir[7:5]];
            alu_op <= CMP_OP;
          end
          state <= EXEC;
        end
        EXEC: begin
          res_q <= alu_result;
          eq_q  <= alu_eq;
          grt_q <= alu_grt;
          state <= WB;
        end
        WB: begin
          done <= 1'b1;
          if (is_alu) begin
            if (rd != 3'd0) rf[rd] <= res_q;
          end else if (is_li) begin
            if (rd != 3'd0) rf[rd] <= imm_ext;
          end else if (is_br) begin
            br_valid  <= 1'b1;
            br_offset <= off_ext;
            case (opcode)
              5'd16:   br_taken <= eq_q;
              5'd17:   br_taken <= !eq_q;
              default: br_taken <= grt_q;
            endcase
          end else begin
            err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0000;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_op;
  logic        alu_zero, alu_neg, alu_grt, alu_eq;
  logic        done, err, br_valid, br_taken;
  logic [15:0] br_offset;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.DATA_WIDTH(16), .CMP_OP(5'd1)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_grt(alu_grt), .alu_eq(alu_eq),
    .done(done), .err(err), .br_valid(br_valid), .br_taken(br_taken),
    .br_offset(br_offset), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Bench ALU: op0 add, op1 subtract, op2 and, others or.
  always_comb begin
    case (alu_op)
      5'd0:    alu_result = alu_a + alu_b;
      5'd1:    alu_result = alu_a - alu_b;
      5'd2:    alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
    alu_zero = (alu_result == 16'h0000);
    alu_neg  = alu_result[15];
    alu_eq   = (alu_a == alu_b);
    alu_grt  = ($signed(alu_a) > $signed(alu_b));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic        is_br;
    logic        exp_err;
    logic        exp_brt;
    logic [15:0] exp_off;
    logic [2:0]  dbg_addr;
    logic [15:0] exp_dbg;
  } vec_t;

  vec_t vecs [11];

  task automatic run_vec(input vec_t v);
    int   cyc;
    bit   seen;
    bit   rdy_bad;
    logic [4:0] op_exec;
    @(negedge clk);
    chk("ready_idle", {31'd0, instr_ready}, 32'd1);
    instr       = v.instr;
    dbg_addr    = v.dbg_addr;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    cyc = 0; seen = 0; rdy_bad = 0; op_exec = 5'h1f;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (instr_ready) rdy_bad = 1;
        if (cyc == 1) op_exec = alu_op;
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end
    end
    chk("done_latency", seen ? cyc : 99, 32'd3);
    chk("ready_low", {31'd0, rdy_bad}, 32'd0);
    chk("err", {31'd0, err}, {31'd0, v.exp_err});
    chk("br_valid", {31'd0, br_valid}, {31'd0, v.is_br});
    chk("br_taken", {31'd0, br_taken}, {31'd0, v.exp_brt});
    if (v.is_br) begin
      chk("alu_op_exec", {27'd0, op_exec}, 32'd1);
      chk("br_offset", {16'd0, br_offset}, {16'd0, v.exp_off});
    end
    chk("dbg", {16'd0, dbg_data}, {16'd0, v.exp_dbg});
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int acc;
    int acc_t [2];
    bit dn;

    //            instr     br  err  brt  off       dbg   exp_dbg
    vecs[0]  = '{16'h7902, 0, 0, 0, 16'h0000, 3'd1, 16'h0002};
    vecs[1]  = '{16'h7A03, 0, 0, 0, 16'h0000, 3'd2, 16'h0003};
    vecs[2]  = '{16'h0328, 0, 0, 0, 16'h0000, 3'd3, 16'h0005};
    vecs[3]  = '{16'h815C, 1, 0, 0, 16'hFFFC, 3'd3, 16'h0005};
    vecs[4]  = '{16'h9223, 1, 0, 1, 16'h0003, 3'd1, 16'h0002};
    vecs[5]  = '{16'h0028, 0, 0, 0, 16'h0000, 3'd0, 16'h0000};
    vecs[6]  = '{16'hF800, 0, 1, 0, 16'h0000, 3'd2, 16'h0003};
    vecs[7]  = '{16'h8941, 1, 0, 1, 16'h0001, 3'd2, 16'h0003};
    vecs[8]  = '{16'h0E44, 0, 0, 0, 16'h0000, 3'd6, 16'h0001};
    vecs[9]  = '{16'h7F80, 0, 0, 0, 16'h0000, 3'd7, 16'hFF80};
    vecs[10] = '{16'h8130, 1, 0, 1, 16'hFFF0, 3'd7, 16'hFF80};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_brv", {31'd0, br_valid}, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_br_off", {16'd0, br_offset}, 32'd0);
    dbg_addr = 3'd1;
    #1 chk("rst_r1", {16'd0, dbg_data}, 32'd0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset during EXEC aborts LI r1,5 and clears everything.
    @(negedge clk);
    instr = 16'h7905; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("mid_rst_alu_op", {27'd0, alu_op}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = a[2:0];
      #1 chk("mid_rst_reg", {16'd0, dbg_data}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) dn = 1;
    end
    chk("post_rst_no_done", {31'd0, dn}, 32'd0);
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    dbg_addr = 3'd1;
    #1 chk("post_rst_r1", {16'd0, dbg_data}, 32'd0);

    // Back-to-back with instr_valid held high.
    acc = 0; acc_t[0] = 0; acc_t[1] = 0;
    instr = 16'h7CFF; instr_valid = 1'b1;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      @(negedge clk);
      if (acc == 1) instr = 16'h7D7F;
      if (instr_ready) begin
        acc_t[acc] = c;
        acc++;
      end
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    chk("b2b_accepts", acc, 32'd2);
    chk("b2b_spacing", acc_t[1] - acc_t[0], 32'd4);
    repeat (5) @(negedge clk);
    dbg_addr = 3'd4;
    #1 chk("b2b_r4", {16'd0, dbg_data}, 32'h0000FFFF);
    dbg_addr = 3'd5;
    #1 chk("b2b_r5", {16'd0, dbg_data}, 32'h0000007F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Multi-cycle execute controller that drives the ALU's a/b/op inputs and consumes its result/zero/neg/grt/eq outputs.
- Accepts 16-bit instructions from fetch over a valid/ready handshake.
- Holds an 8-entry register file and sequences decode, execute and writeback.
- Reports branch decisions to fetch. Sits between the fetch stage and the ALU in the MIPS datapath.

Parameters:
DATA_WIDTH, 16, width of registers, ALU operands and result
CMP_OP, 5'd1, ALU op code driven for branch compares (subtract)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  fetch presents instruction
instr_ready  out  1  controller can accept instruction
instr  in  16  instruction word
alu_a  out  DATA_WIDTH  ALU operand a (signed)
alu_b  out  DATA_WIDTH  ALU operand b (signed)
alu_op  out  5  ALU operation select
alu_result  in  DATA_WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
alu_zero, alu_neg, alu_grt, alu_eq  in  1 each  ALU flags
done  out  1  one-cycle pulse, instruction retired
err  out  1  one-cycle pulse with done, illegal opcode
br_valid  out  1  one-cycle pulse with done for branch instructions
br_taken  out  1  branch condition true, valid with br_valid
br_offset  out  DATA_WIDTH  sign-extended 5-bit offset, valid with br_valid
dbg_addr  in  3  register file debug read address
dbg_data  out  DATA_WIDTH  combinational read of reg[dbg_addr]

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset: state IDLE, all registers incl. IR and regfile = 0, alu_a/alu_b/alu_op = 0, done/err/br_valid/br_taken = 0, br_offset = 0. Reset mid-instruction aborts it with no writeback.
- Instruction format: opcode = instr[15:11].
  - Opcodes 0-14, ALU R-type: rd[10:8], rs[7:5], rt[4:2]; alu_op = opcode.
  - Opcode 15, LI: rd[10:8], imm8[7:0] sign-extended.
  - Opcodes 16 BEQ, 17 BNE, 18 BGT: rs[10:8], rt[7:5], off[4:0] signed.
  - Opcodes 19-31: illegal.
- FSM states IDLE -> DECODE -> EXEC -> WB -> IDLE. No stalls.
- IDLE:
  - instr_ready = 1 only in IDLE.
  - instr_valid && instr_ready captures instr into IR, then DECODE.
- DECODE: register alu_a = reg[rs] and alu_b = reg[rt].
  - ALU op: alu_op = opcode.
  - Branch: alu_op = CMP_OP, with a = reg[rs], b = reg[rt].
  - LI or illegal: alu_a/alu_b/alu_op hold previous values.
- EXEC: sample alu_result and alu_eq/alu_grt into internal capture registers.
- WB:
  - ALU op: reg[rd] <= captured result.
  - LI: reg[rd] <= sext(imm8).
  - Branch: br_valid = 1.
    - br_taken: BEQ = eq, BNE = !eq, BGT = grt (signed rs > rt).
    - br_offset = sext(off).
  - Illegal: err = 1, no write.
  - done = 1 for every instruction.
- Timing: done asserts exactly 3 cycles after the accepting edge. Throughput is one instruction per 4 cycles.
- Register 0: reg[0] reads 0 always; writes to rd = 0 are discarded.
- Arithmetic: all arithmetic lives in the ALU; the controller only sign-extends. Overflow/wrap is whatever the ALU returns, stored unmodified.
- dbg_data reflects a write on the cycle after the WB edge.

Test Plan:
- Load/add: after reset, send 0x7902 (LI r1,2), 0x7A03 (LI r2,3), 0x0328 (op0 r3=r1+r2), with a bench ALU model where op0 = a+b.
  - Required: dbg r1=2, r2=3, r3=5.
  - Required: each done pulse arrives 3 cycles after its accept; instr_ready is low for 3 cycles after each accept.
- BEQ not taken: with r1=2, r2=3, send 0x815C (BEQ r1,r2,-4).
  - Required: alu_op = CMP_OP in EXEC; br_valid=1, br_taken=0, br_offset=0xFFFC.
- BGT taken: send 0x9223 (BGT r2,r1,3).
  - Required: br_valid=1, br_taken=1, br_offset=3; no register changes.
- r0 and illegal opcode:
  - 0x0028 (write r0): dbg r0 stays 0.
  - 0xF800 (opcode 31): done=1 and err=1 in the same cycle; no register changes.
- Reset mid-op: accept 0x7905 (LI r1,5) and assert rst during EXEC.
  - Required: immediately state IDLE, done=0, all regs 0, instr_ready=1 after rst deasserts; r1 remains 0.
- Back-to-back with signed values: hold instr_valid high continuously with LI r4,-1 (0x7CFF) then LI r5,127 (0x7D7F).
  - Required: second accept exactly 4 cycles after the first; r4=0xFFFF, r5=0x007F.
